fft_data_input: RTL

Source-side buffer for the AXI FFT path. Software loads one frame of NFFT complex samples into a word-addressed RAM through a synchronous write port. A start pulse then streams the frame to the FFT core as NFFT beats on an AXI4-Stream master, with tlast on the final beat. It is the transmit counterpart of the FFT output capture buffer and uses the same RAM word layout.

---
 rtl/fft_data_input.sv | 77 +++++++
 1 files changed

// File: rtl/fft_data_input.sv
// Frame source for the FFT core: a 2*NFFT x 32 word RAM loaded by software,
// streamed out as NFFT complex beats {IM, RE} on an AXI4-Stream master.
module fft_data_input #(
  parameter int NFFT = 8,
  localparam int AW = $clog2(NFFT*2),
  localparam int IW = $clog2(NFFT)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          wEn,
  input  logic [AW-1:0] wAddr,
  input  logic [31:0]   wData,
  input  logic          start,
  output logic          tvalid,
  input  logic          tready,
  output logic          tlast,
  output logic [63:0]   tdata,
  output logic          busy,
  output logic          sent
);

  typedef enum logic [1:0] {IDLE, SENDING, DONE} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] i_q, i_d;
  logic          sent_q, sent_d;
  logic [31:0]   ram [NFFT*2];

  wire last_idx = (i_q == IW'(NFFT-1));

  // Writes are only taken in IDLE so an in-flight frame can never change.
  always_ff @(posedge clk) begin
    if (wEn && state_q == IDLE) ram[wAddr] <= wData;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      i_q     <= '0;
      sent_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      sent_q  <= sent_d;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    sent_d  = 1'b0;
    case (state_q)
      IDLE: begin
        i_d = '0;
        if (start) state_d = SENDING;
      end
      SENDING: begin
        if (tready) begin
          i_d = i_q + 1'b1;
          if (last_idx) begin
            state_d = DONE;
            sent_d  = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign tvalid = (state_q == SENDING);
  assign busy   = (state_q != IDLE);
  assign sent   = sent_q;
  assign tlast  = tvalid && last_idx;
  assign tdata  = {ram[{i_q, 1'b1}], ram[{i_q, 1'b0}]};

endmodule
